// File: rtl/dual_issue_dispatcher.sv
// dual_issue_dispatcher: instruction FIFO issuing one (unified) or up to two independent (split) instructions per cycle.
module dual_issue_dispatcher #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       mode,
  input  logic                       in_valid,
  input  logic [31:0]                in_instr,
  output logic                       in_ready,
  input  logic                       stall,
  input  logic                       flush,
  output logic                       validA,
  output logic                       validB,
  output logic [31:0]                instrA,
  output logic [31:0]                instrB,
  output logic [6:0]                 opcodeA,
  output logic [6:0]                 opcodeB,
  output logic [2:0]                 funct3A,
  output logic [2:0]                 funct3B,
  output logic [6:0]                 funct7A,
  output logic [6:0]                 funct7B,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [31:0] h0, h1;
  logic push, pair, hazard;
  logic [CW-1:0] pops;
  function automatic logic alu_op(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011};
  endfunction
  function automatic logic writes_rd(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0010011, 7'b0000011};
  endfunction
  function automatic logic uses_rs2(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0100011};
  endfunction
  assign h0 = mem[rd_ptr];
  assign h1 = mem[rd_ptr + AW'(1)];
  assign in_ready = count < CW'(DEPTH);
  assign push = in_valid && in_ready && !flush;
  // RAW: H1 may not read a register H0 is about to write
  assign hazard = writes_rd(h0[6:0]) && h0[11:7] != 5'd0 &&
                  (h1[19:15] == h0[11:7] || (uses_rs2(h1[6:0]) && h1[24:20] == h0[11:7]));
  assign pair = !mode && count >= CW'(2) && alu_op(h0[6:0]) && alu_op(h1[6:0]) && !hazard;
  assign pops = (stall || flush || count == '0) ? '0 : pair ? CW'(2) : CW'(1);
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_instr;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      validA <= 1'b0;
      validB <= 1'b0;
      instrA <= '0;
      instrB <= '0;
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      validA <= 1'b0;
      validB <= 1'b0;
      instrA <= '0;
      instrB <= '0;
    end else begin
      count  <= count + CW'(push) - pops;
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= rd_ptr + AW'(pops);
      if (!stall) begin
        validA <= count != '0;
        instrA <= count != '0 ? h0 : '0;
        validB <= pair;
        instrB <= pair ? h1 : '0;
      end
    end
  end
  assign opcodeA = instrA[6:0];
  assign opcodeB = instrB[6:0];
  assign funct3A = instrA[14:12];
  assign funct3B = instrB[14:12];
  assign funct7A = instrA[31:25];
  assign funct7B = instrB[31:25];
endmodule

// File: tb/tb_dual_issue_dispatcher.sv
// tb_dual_issue_dispatcher: directed and random stimulus checked against a queue-based dispatch model.
module tb_dual_issue_dispatcher;
  localparam int DEPTH = 4;
  localparam logic [31:0] ADD  = 32'h003100B3;
  localparam logic [31:0] SUB  = 32'h40628233;
  localparam logic [31:0] ADD7 = 32'h002083B3;
  localparam logic [31:0] JALR = 32'h000280E7;
  logic clk = 1'b0, rst_n, mode, in_valid, in_ready, stall, flush;
  logic validA, validB;
  logic [31:0] in_instr, instrA, instrB;
  logic [6:0] opcodeA, opcodeB, funct7A, funct7B;
  logic [2:0] funct3A, funct3B;
  logic [2:0] count;
  int checks = 0, errors = 0;
  logic [31:0] q[$];
  logic ea = 1'b0, eb = 1'b0, last_acc;
  logic [31:0] ia = '0, ib = '0;
  logic [31:0] w[6];

  dual_issue_dispatcher #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .stall(stall), .flush(flush), .validA(validA), .validB(validB),
    .instrA(instrA), .instrB(instrB), .opcodeA(opcodeA), .opcodeB(opcodeB),
    .funct3A(funct3A), .funct3B(funct3B), .funct7A(funct7A), .funct7B(funct7B), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit pairable(input logic [31:0] a, input logic [31:0] b);
    bit alu_a = a[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23};
    bit alu_b = b[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23};
    bit wr = a[6:0] inside {7'h33, 7'h13, 7'h03};
    bit r2 = b[6:0] inside {7'h33, 7'h23};
    bit haz = wr && a[11:7] != 0 && (b[19:15] == a[11:7] || (r2 && b[24:20] == a[11:7]));
    return alu_a && alu_b && !haz;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [6:0] op;
    case ($urandom_range(0, 6))
      0: op = 7'h33;
      1: op = 7'h13;
      2: op = 7'h03;
      3: op = 7'h23;
      4: op = 7'h67;
      5: op = 7'h37;
      default: op = 7'h63;
    endcase
    return {($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 3'($urandom), 5'($urandom_range(0, 3)), op};
  endfunction

  task automatic step(input logic v, input logic [31:0] wd, input logic st, input logic fl, input logic md);
    logic ready, pr;
    in_valid = v; in_instr = wd; stall = st; flush = fl; mode = md;
    #1;
    ready = q.size() < DEPTH;
    chk("in_ready", 32'(in_ready), 32'(ready));
    if (fl) begin
      q.delete(); ea = 0; eb = 0; ia = 0; ib = 0;
    end else begin
      if (!st) begin
        if (q.size() == 0) begin
          ea = 0; eb = 0; ia = 0; ib = 0;
        end else begin
          pr = !md && q.size() >= 2 && pairable(q[0], q[1]);
          ea = 1; ia = q.pop_front();
          eb = pr; ib = pr ? q.pop_front() : 32'h0;
        end
      end
      if (v && ready) q.push_back(wd);
    end
    last_acc = !fl && v && ready;
    @(posedge clk); #1;
    chk("validA", 32'(validA), 32'(ea));
    chk("validB", 32'(validB), 32'(eb));
    chk("instrA", instrA, ia);
    chk("instrB", instrB, ib);
    chk("opcodeA", 32'(opcodeA), 32'(ia[6:0]));
    chk("funct3A", 32'(funct3A), 32'(ia[14:12]));
    chk("funct7A", 32'(funct7A), 32'(ia[31:25]));
    chk("opcodeB", 32'(opcodeB), 32'(ib[6:0]));
    chk("funct3B", 32'(funct3B), 32'(ib[14:12]));
    chk("funct7B", 32'(funct7B), 32'(ib[31:25]));
    chk("count", 32'(count), 32'(q.size()));
  endtask

  task automatic send(input logic [31:0] wd, input logic st, input logic md);
    int n = 0;
    do begin
      step(1'b1, wd, st, 1'b0, md);
      n++;
    end while (!last_acc && n < 20);
    chk("send_accept", 32'(last_acc), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b1; in_valid = 1'b0; in_instr = '0; stall = 1'b0; flush = 1'b0;
    #2;
    chk("rst_count", 32'(count), 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_validA", 32'(validA), 0);
    chk("rst_instrB", instrB, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    // unified
    step(1, ADD, 0, 0, 1);
    step(1, SUB, 0, 0, 1);
    chk("uni_op0", 32'(opcodeA), 32'h33);
    chk("uni_f7_0", 32'(funct7A), 32'h00);
    step(0, 0, 0, 0, 1);
    chk("uni_f7_1", 32'(funct7A), 32'h20);
    chk("uni_vB", 32'(validB), 0);
    // split pair
    step(1, ADD, 1, 0, 0);
    step(1, SUB, 1, 0, 0);
    chk("pre_pair_count", 32'(count), 2);
    step(0, 0, 0, 0, 0);
    chk("pair_vB", 32'(validB), 1);
    chk("pair_iA", instrA, ADD);
    chk("pair_iB", instrB, SUB);
    chk("pair_count", 32'(count), 0);
    step(0, 0, 0, 0, 0);
    // RAW hazard then JALR
    step(1, ADD, 1, 0, 0);
    step(1, ADD7, 1, 0, 0);
    step(1, JALR, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("raw_vB", 32'(validB), 0);
    chk("raw_iA", instrA, ADD);
    step(0, 0, 0, 0, 0);
    chk("add7_vB", 32'(validB), 0);
    step(0, 0, 0, 0, 0);
    chk("jalr_iA", instrA, JALR);
    chk("jalr_vB", 32'(validB), 0);
    // backpressure
    for (int i = 0; i < 5; i++) w[i] = rnd_instr();
    for (int i = 0; i < 4; i++) step(1, w[i], 1, 0, 1);
    chk("bp_count", 32'(count), 4);
    chk("bp_ready", 32'(in_ready), 0);
    step(1, w[4], 1, 0, 1);
    chk("bp_held", 32'(last_acc), 0);
    send(w[4], 0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
    // flush with occupied FIFO and live lane A
    for (int i = 0; i < 6; i++) w[i] = rnd_instr();
    step(1, w[0], 0, 0, 1);
    step(1, w[1], 0, 0, 1);
    step(1, w[2], 1, 0, 1);
    step(1, w[3], 1, 0, 1);
    chk("pre_flush_count", 32'(count), 3);
    chk("pre_flush_vA", 32'(validA), 1);
    step(1, w[4], 0, 1, 1);
    chk("flush_count", 32'(count), 0);
    chk("flush_vA", 32'(validA), 0);
    step(0, 0, 0, 0, 1);
    chk("flush_drop", 32'(validA), 0);
    // random
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 7, rnd_instr(), $urandom_range(0, 3) == 0,
           $urandom_range(0, 32) == 0, $urandom_range(0, 1) != 0);
    // asynchronous mid-operation reset
    step(1, rnd_instr(), 1, 0, 0);
    step(1, rnd_instr(), 1, 0, 0);
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_ready", 32'(in_ready), 1);
    chk("arst_validA", 32'(validA), 0);
    chk("arst_instrA", instrA, 0);
    q.delete(); ea = 0; eb = 0; ia = 0; ib = 0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    step(0, 0, 0, 0, 1);
    step(1, ADD, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("post_rst_iA", instrA, ADD);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dual_issue_dispatcher.md
# dual_issue_dispatcher

Instruction dispatch buffer that feeds the dual-lane (A/B) ALU control path. It accepts 32-bit RISC-V instructions from fetch over a valid/ready handshake and buffers them in a small FIFO. Each cycle it issues either one instruction on lane A (unified mode) or up to two independent instructions on lanes A and B (split mode). Its registered outputs drive the control unit's opcode/funct3/funct7 inputs directly.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mode  in  1  1 = unified (lane A only), 0 = split (dual issue)
- in_valid  in  1  fetch has an instruction
- in_instr  in  32  instruction word
- in_ready  out  1  FIFO can accept this cycle
- stall  in  1  downstream hold; freezes issue registers and FIFO pops
- flush  in  1  synchronous discard of all buffered and issued instructions
- validA, validB  out  1  lane carries a real instruction
- instrA, instrB  out  32  registered issued instruction; 0 when lane invalid
- opcodeA/B  out  7  instrX[6:0]
- funct3A/B  out  3  instrX[14:12]
- funct7A/B  out  7  instrX[31:25]
- count  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Reset (async, rst_n=0): count=0, pointers=0, validA=validB=0, instrA=instrB=0, in_ready=1.
- in_ready = (count < DEPTH). Depends only on the registered count, not on the same-cycle pop.
- Push on the edge where in_valid && in_ready && !flush. Push and pop in the same cycle are legal; count changes by push − pops.
- Issue decision is made at each edge with stall=0 and flush=0:
  - Empty FIFO: validA=validB=0; instrA=instrB=0.
  - Unified (mode=1): lane A gets the head and 1 entry pops. validB=0, instrB=0.
  - Split (mode=0): lane A gets the head (H0). Lane B gets H0+1 (H1) only if all of the following hold; otherwise lane B is NOP and 1 entry pops. On a pair, 2 entries pop.
    - count ≥ 2.
    - Neither H0 nor H1 is JALR (1100111).
    - Both opcodes are in {0110011, 0010011, 0000011, 0100011}.
    - No RAW hazard. A hazard exists when H0 writes rd (R, I, LOAD), H0.rd ≠ 0, and H1.rs1 == H0.rd, or H1 uses rs2 (R, STORE) and H1.rs2 == H0.rd.
- Unknown opcodes issue on lane A alone and are never paired.
- Program order is preserved: lane A is always older than lane B.
- stall=1: all issue outputs hold their values, nothing pops, and pushes continue while in_ready.
- flush=1: on that edge count=0, pointers reset, validA=validB=0, instrA=instrB=0, and in_valid is ignored.
- Priority: flush > stall > normal issue.
- mode is sampled at each issue edge. A change affects only the next issue; already-issued outputs are unchanged.
- Pointers wrap modulo DEPTH. An empty FIFO is never popped; a full FIFO is never pushed.

## Timing
- An instruction accepted at edge N can appear on validA/validB at edge N+1 at the earliest. There is no same-edge bypass.
- Issue outputs are registered. opcode/funct fields are pure slices of the registers.
- Throughput: 1 instruction/cycle in unified mode, 2 instructions/cycle in split mode when pairable.
- in_ready deasserts in the cycle after count reaches DEPTH, and reasserts the cycle after a pop drops count below DEPTH.
- A reset assertion mid-operation clears everything immediately, with no dependence on clk.

## Test plan
- Reset: hold rst_n=0 → validA=validB=0, instrA=instrB=0, count=0, in_ready=1. Release, keep in_valid=0 → outputs stay 0.
- Unified: mode=1, push ADD x1,x2,x3 (0x003100B3) then SUB x4,x5,x6 (0x40628233) → next two issue cycles show opcodeA=0110011. funct7A is first 0000000, then 0100000. validB=0 throughout.
- Split pair: mode=0, preload 0x003100B3 and 0x40628233, then release stall → one cycle with validA=validB=1, instrA=0x003100B3, instrB=0x40628233; count drops by 2.
- RAW and JALR: mode=0, queue 0x003100B3, ADD x7,x1,x2 (0x002083B3), then JALR x1,0(x5) (0x000280E7) → three single issues on lane A with validB=0 each time. The first is blocked by the RAW hazard on x1; the JALR is never paired.
- Backpressure: stall=1, push 5 instructions with DEPTH=4 → count=4, in_ready=0, 5th word held by the source. Release stall → in_ready=1 next cycle and the 5th word is accepted. Order is preserved.
- Flush: FIFO holding 3 entries, validA=1, assert flush together with in_valid=1 → next cycle count=0, validA=validB=0, instr outputs 0; the concurrent word is dropped.
